// File: rtl/intt_twiddle_gen_pkg.sv
// Shared NTT constants over Q = 7681, N = 256, plus the index helpers and twiddle FSM states.
// Used by both the forward and the inverse twiddle providers.
package ntt_pkg;
  localparam int unsigned Q         = 7681;
  localparam int unsigned N         = 256;
  localparam int unsigned LOGN      = 8;
  localparam int unsigned BARRETT_M = 8736;  // floor(2^26 / Q)
  localparam int unsigned N_INV     = 7651;  // 256^-1 mod Q

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, READY} tw_state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[7-i];
    return r;
  endfunction
endpackage

// File: rtl/intt_twiddle_gen_if.sv
// Control and read-port bundle between the NTT sequencer (master) and the INTT twiddle generator (slave).
// Reads are 1-cycle latency and have no backpressure; rd_valid qualifies rd_data.
interface intt_twiddle_gen_if;
  logic        start;
  logic [15:0] psi_inv;
  logic        busy;
  logic        ready;
  logic        done;
  logic        root_ok;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic        rd_bitrev;
  logic        rd_valid;
  logic [15:0] rd_data;

  modport master (output start, psi_inv, rd_en, rd_addr, rd_bitrev,
                  input  busy, ready, done, root_ok, rd_valid, rd_data);
  modport slave  (input  start, psi_inv, rd_en, rd_addr, rd_bitrev,
                  output busy, ready, done, root_ok, rd_valid, rd_data);
endinterface

// File: rtl/mod_mult_q.sv
// a*b mod Q for a,b < Q: a registered multiply stage, then Barrett reduction with one corrective subtract.
// The reduced result is combinational from the product register; the caller's flop closes the second stage.
module mod_mult_q
  import ntt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);
  logic [25:0] prod_q;
  logic [13:0] q_est;
  logic [13:0] r;

  always_ff @(posedge clk) begin
    if (rst)     prod_q <= '0;
    else if (en) prod_q <= 26'(a * b);
  end

  // Quotient estimate is at most one short, so the remainder stays below 2Q.
  always_comb begin
    q_est = 14'((40'(prod_q) * 40'(BARRETT_M)) >> 26);
    r     = 14'(prod_q - 26'(q_est) * 26'(Q));
    if (r >= 14'(Q)) r = r - 14'(Q);
    p = {2'b00, r};
  end
endmodule

// File: rtl/intt_twiddle_gen.sv
// Builds psi_inv^k mod Q (k = 0..255) in a 256x16 table at 2 cycles per entry, checks psi_inv^256 == Q-1,
// then serves 1-cycle-latency reads (natural or bit-reversed); reads outside READY are dropped.
module intt_twiddle_gen
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  intt_twiddle_gen_if.slave tw
);
  tw_state_t   state_q, state_d;
  logic [7:0]  k_q;
  logic [15:0] acc_q, psi_q, prod;
  logic        busy_q, ready_q, done_q, root_ok_q, rd_valid_q;
  logic [15:0] rd_data_q;
  logic        accept, issue, last, rd_fire;
  logic [7:0]  ram_addr;
  logic [15:0] mem [N];

  mod_mult_q u_mul (
    .clk (clk),
    .rst (rst),
    .en  (issue),
    .a   (acc_q),
    .b   (psi_q),
    .p   (prod)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    last    = 1'b0;
    rd_fire = 1'b0;
    unique case (state_q)
      IDLE: if (tw.start) begin
        accept  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        issue   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        last    = (k_q == 8'd255);
        state_d = last ? READY : ISSUE;
      end
      READY: begin
        // A start in the same cycle as a read wins; the read is dropped.
        if (tw.start) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end else begin
          rd_fire = tw.rd_en;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      acc_q      <= 16'd1;
      psi_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      root_ok_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= 1'b0;
      rd_valid_q <= rd_fire;
      if (accept) begin
        psi_q     <= tw.psi_inv;
        acc_q     <= 16'd1;
        k_q       <= '0;
        busy_q    <= 1'b1;
        ready_q   <= 1'b0;
        root_ok_q <= 1'b0;
      end
      if (state_q == WAIT) begin
        acc_q <= prod;
        if (last) begin
          root_ok_q <= (prod == 16'(Q - 1));
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          ready_q   <= 1'b1;
        end else begin
          k_q <= k_q + 8'd1;
        end
      end
    end
  end

  // Single-port table: written only in ISSUE, read only in READY.
  assign ram_addr = issue ? k_q : (tw.rd_bitrev ? bitrev8(tw.rd_addr) : tw.rd_addr);

  always_ff @(posedge clk) begin
    if (issue) mem[ram_addr] <= acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_fire) rd_data_q <= mem[ram_addr];
  end

  assign tw.busy     = busy_q;
  assign tw.ready    = ready_q;
  assign tw.done     = done_q;
  assign tw.root_ok  = root_ok_q;
  assign tw.rd_valid = rd_valid_q;
  assign tw.rd_data  = rd_data_q;
endmodule
